// File: rtl/input_capture_pkg.sv
// Shared encodings for the timer input-capture channel.
package input_capture_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } cap_state_e;

endpackage

// File: rtl/capture_edge_detect.sv
// Pin synchronizer, optional glitch filter (INPUT_CAPTURE_FILTER_EN), priming
// and edge detector producing a single-cycle event strobe.
module capture_edge_detect
    import input_capture_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pin_i,
    input  logic [1:0] edge_sel_i,
    output logic       event_o
);

`ifdef INPUT_CAPTURE_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam int PRIME_LEN = 2 + (FILTER_EN ? FILTER_LEN : 0);
    localparam int PRIME_W   = 5;

    logic               s1_q, s2_q, p_q;
    logic [PRIME_W-1:0] prime_q;
    logic               primed;
    logic               lvl, lvl_next;
    logic               rise_en, fall_en;

`ifdef INPUT_CAPTURE_FILTER_EN
    logic       f_q, f_d;
    logic [3:0] run_q, run_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        f_d   = f_q;
        run_d = '0;
        if (s2_q != f_q) begin
            if (run_q == 4'(FILTER_LEN - 1)) begin
                f_d = s2_q;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_q   <= 1'b0;
            run_q <= '0;
        end else begin
            f_q   <= f_d;
            run_q <= run_d;
        end
    end

    assign lvl      = f_q;
    assign lvl_next = f_d;
`else
    assign lvl      = s2_q;
    assign lvl_next = s1_q;
`endif

    assign primed = (prime_q == PRIME_W'(PRIME_LEN));

    // While priming, p follows the level one step ahead so it already matches
    // the detector input when events unmask; a pin high out of reset is no edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            p_q     <= 1'b0;
            prime_q <= '0;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
            p_q  <= primed ? lvl : lvl_next;
            if (!primed) begin
                prime_q <= prime_q + PRIME_W'(1);
            end
        end
    end

    assign rise_en = (edge_sel_i == EDGE_RISE) || (edge_sel_i == EDGE_BOTH);
    assign fall_en = (edge_sel_i == EDGE_FALL) || (edge_sel_i == EDGE_BOTH);

    assign event_o = primed & ((lvl & ~p_q & rise_en) | (~lvl & p_q & fall_en));

endmodule

// File: rtl/input_capture.sv
// Timer input-capture channel: capture register, sticky capture/overrun flags.
// Glitch filter enabled by defining INPUT_CAPTURE_FILTER_EN.
module input_capture
    import input_capture_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FILTER_LEN = 3
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic [DATA_W-1:0] ivCuenta,
    input  logic              iCapturePin,
    input  logic [1:0]        ivEdgeSelect,
    input  logic              iAck,
    output logic [DATA_W-1:0] ovCaptureValue,
    output logic              oCaptureFlag,
    output logic              oOverrunFlag
);

    logic              cap_event;
    cap_state_e        state_q, state_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              overrun_q, overrun_d;

    capture_edge_detect #(
        .FILTER_LEN(FILTER_LEN)
    ) u_edge (
        .clk_i     (iClk),
        .rst_i     (iReset),
        .pin_i     (iCapturePin),
        .edge_sel_i(ivEdgeSelect),
        .event_o   (cap_event)
    );

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        overrun_d = overrun_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (cap_event) begin
                    value_d = ivCuenta;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // Ack together with a new event restarts the capture rather than dropping it.
                if (cap_event && iAck) begin
                    value_d   = ivCuenta;
                    overrun_d = 1'b0;
                end else if (cap_event) begin
                    overrun_d = 1'b1;
                end else if (iAck) begin
                    overrun_d = 1'b0;
                    state_d   = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q   <= ST_EMPTY;
            value_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            overrun_q <= overrun_d;
        end
    end

    assign ovCaptureValue = value_q;
    assign oCaptureFlag   = (state_q == ST_FULL);
    assign oOverrunFlag   = overrun_q;

endmodule

// File: doc/input_capture.md
Name: input_capture

Overview:
Timer input-capture channel. It latches the free-running 8-bit timer count (ivCuenta) when a selected edge occurs on an external pin, and raises a sticky capture flag that the CPU clears with an acknowledge pulse. It is the receive-side counterpart to the timer's output-compare channel and shares the same count bus. A second event before acknowledge sets a sticky overrun flag.

Parameters:
DATA_W, 8, width of the count bus and the capture register.
FILTER_LEN, 3, consecutive equal samples needed to accept a pin level; used only when the filter macro is defined; legal range 2..15.

Ports:
iClk  in  1  system clock; all state updates on the rising edge.
iReset  in  1  asynchronous, active-high reset; clears all state immediately.
ivCuenta  in  DATA_W  current timer count.
iCapturePin  in  1  asynchronous external event pin.
ivEdgeSelect  in  2  00 = disabled, 01 = rising, 10 = falling, 11 = both edges.
iAck  in  1  one-cycle pulse from CPU that clears the flags.
ovCaptureValue  out  DATA_W  latched count.
oCaptureFlag  out  1  capture is pending.
oOverrunFlag  out  1  an event was lost while a capture was pending.

Behaviour:
- Reset (asynchronous): ovCaptureValue=0, oCaptureFlag=0, oOverrunFlag=0; synchronizer, previous-level and filter registers=0; FSM=EMPTY; priming counter=0.
- Pin path: two-flop synchronizer (s1, s2) feeding previous-level register p. Event = (s2 & ~p & rise_en) | (~s2 & p & fall_en).
- Priming: events are masked until 2 rising clock edges after reset deassertion, so a pin held high out of reset is not a spurious rising edge. The p register still tracks the pin during priming.
- Latency: the pin changes before edge e1. The capture happens on e3. Flag and value are visible after e3. ovCaptureValue holds the ivCuenta value present in the cycle before e3.
- Disabled (00): no events. p keeps tracking the pin, so enabling never generates a stale edge. Changing ivEdgeSelect never creates an event on its own.
- FSM, two states:
  - EMPTY, event: load ovCaptureValue from ivCuenta, set oCaptureFlag, go to FULL.
  - EMPTY, iAck: no effect.
  - FULL, event without iAck: ovCaptureValue is held (the first capture wins), oOverrunFlag=1, stay in FULL.
  - FULL, iAck without event: clear both flags, go to EMPTY. ovCaptureValue holds its last value.
  - FULL, iAck and event in the same cycle: load the new value, oCaptureFlag stays 1, oOverrunFlag=0, stay in FULL.
- ovCaptureValue is captured as-is; timer wrap-around (FF to 00) is software's concern.
- Reset asserted mid-operation takes effect immediately and re-arms priming.

Optional Feature:
- INPUT_CAPTURE_FILTER_EN defined:
  - A digital glitch filter sits between s2 and the edge detector.
  - The filtered level f changes only after FILTER_LEN consecutive s2 samples differ from f; any agreeing sample resets the run counter.
  - Events are detected on f versus p.
  - Capture latency becomes 3+FILTER_LEN edges; pulses shorter than FILTER_LEN clocks are rejected.
  - Priming lengthens to 2+FILTER_LEN edges.
- Not defined: no filter, no counter logic, latency exactly 3 edges, and FILTER_LEN is ignored.

Decomposition:
- Package input_capture_pkg holds:
  - edge-select encodings EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH;
  - FSM state constants ST_EMPTY, ST_FULL;
  - the default DATA_W.
- Sub-module capture_edge_detect holds the synchronizer, the optional filter, priming and p register, and outputs a single-cycle event strobe. The top level contains the FSM, the capture register and the flags.

Test Plan:
- Rising select 01, ivCuenta incrementing from 0x10, pin rises before edge e1 -> after e3 oCaptureFlag=1 and ovCaptureValue = the count in the cycle before e3 (0x12 if aligned at 0x10 on e1).
- Capture pending, second rising edge with no ack -> oOverrunFlag=1 and ovCaptureValue unchanged; iAck pulse -> both flags 0 next cycle.
- Select 11, pin toggles high then low 10 clocks apart, ack between them -> two captures whose values differ by 10.
- iAck on the same cycle as a new event while FULL -> flag stays 1, overrun 0, value updated to the new count.
- Pin held high through reset release, select 01 -> no capture; a later falling then rising edge -> exactly one capture.
- With INPUT_CAPTURE_FILTER_EN and FILTER_LEN=3: a 2-clock high glitch -> no capture; a 3-clock high pulse -> capture on edge 6 after the transition.
